// File: rtl/nrs_index_seq_gen.sv
// nrs_index_seq_gen: sequential NRS demap index generator for the NB-IoT receiver.
// Latches the cell ID and port count on start, reduces the ID mod 6 over seven
// fixed cycles, then streams each NRS subcarrier index for one slot over a
// valid/ready handshake.
// Optional build macro: NRS_CELL_ID_CHECK_EN adds the id_err output and rejects
// cell IDs above 503.
module nrs_index_seq_gen #(
    parameter int ID_W      = 9,
    parameter int MAX_PORTS = 2,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ID_W-1:0]  N_cell_ID,
    input  logic             num_ports,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] index_demap,
    output logic [2:0]       v_shift,
    output logic [1:0]       est_rd_addr,
    output logic             port_idx,
    output logic             last,
    output logic             busy
`ifdef NRS_CELL_ID_CHECK_EN
    ,
    output logic             id_err
`endif
);

    // Wide enough for the ID and for 6<<6 = 384.
    localparam int REM_W = ((ID_W > 9) ? ID_W : 9) + 1;
    localparam logic [REM_W-1:0] SIX = REM_W'(6);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_STREAM
    } state_t;

    state_t           r_state;
    logic [REM_W-1:0] r_rem;
    logic [2:0]       r_k;
    logic             r_nports;
    logic             r_p;
    logic             r_s;
    logic             r_m;

    logic [REM_W-1:0] w_sub;
    logic [REM_W-1:0] w_rem_next;
    logic             w_np;
    logic             w_id_bad;
    logic             w_accept;
    logic [2:0]       w_cnt_nxt;
    logic             w_last_nxt;

    // Index for one entry: 6*m + v + v_shift folded into 0..11.
    // Port 0 uses v=0/3 for s=0/1, port 1 the opposite, so v = 3 when p != s.
    function automatic logic [IDX_W-1:0] f_index(input logic p, input logic s,
                                                 input logic m, input logic [2:0] vs);
        logic [3:0] sum;
        sum = (m ? 4'd6 : 4'd0) + ((p ^ s) ? 4'd3 : 4'd0) + {1'b0, vs};
        if (sum > 4'd11)
            sum = sum - 4'd12;
        return IDX_W'(sum);
    endfunction

    // One restoring-reduction step: subtract 6<<k if it fits.
    assign w_sub      = SIX << r_k;
    assign w_rem_next = (r_rem >= w_sub) ? (r_rem - w_sub) : r_rem;

    // A single-port build never reports the second port.
    assign w_np = (MAX_PORTS > 1) ? num_ports : 1'b0;

`ifdef NRS_CELL_ID_CHECK_EN
    assign w_id_bad = (32'(N_cell_ID) > 32'd503);
`else
    assign w_id_bad = 1'b0;
`endif
    assign w_accept = start & ~w_id_bad;

    // Next entry: {p,s,m} counts with m innermost; last when s=m=1 on the final port.
    assign w_cnt_nxt  = {r_p, r_s, r_m} + 3'd1;
    assign w_last_nxt = (w_cnt_nxt[1:0] == 2'b11) && (w_cnt_nxt[2] == r_nports);

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rem       <= '0;
            r_k         <= '0;
            r_nports    <= 1'b0;
            r_p         <= 1'b0;
            r_s         <= 1'b0;
            r_m         <= 1'b0;
            out_valid   <= 1'b0;
            index_demap <= '0;
            v_shift     <= '0;
            est_rd_addr <= '0;
            port_idx    <= 1'b0;
            last        <= 1'b0;
            busy        <= 1'b0;
`ifdef NRS_CELL_ID_CHECK_EN
            id_err      <= 1'b0;
`endif
        end else begin
`ifdef NRS_CELL_ID_CHECK_EN
            id_err <= (r_state == ST_IDLE) && start && w_id_bad;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rem    <= REM_W'(N_cell_ID);
                        r_nports <= w_np;
                        r_k      <= 3'd6;
                        busy     <= 1'b1;
                        r_state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_next;
                    if (r_k == 3'd0) begin
                        // Reduction done: publish v_shift and present entry 0.
                        v_shift     <= w_rem_next[2:0];
                        r_p         <= 1'b0;
                        r_s         <= 1'b0;
                        r_m         <= 1'b0;
                        index_demap <= f_index(1'b0, 1'b0, 1'b0, w_rem_next[2:0]);
                        est_rd_addr <= 2'b00;
                        port_idx    <= 1'b0;
                        last        <= 1'b0;
                        out_valid   <= 1'b1;
                        r_state     <= ST_STREAM;
                    end else begin
                        r_k <= r_k - 3'd1;
                    end
                end
                ST_STREAM: begin
                    if (out_valid && out_ready) begin
                        if (last) begin
                            out_valid <= 1'b0;
                            last      <= 1'b0;
                            busy      <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_p         <= w_cnt_nxt[2];
                            r_s         <= w_cnt_nxt[1];
                            r_m         <= w_cnt_nxt[0];
                            index_demap <= f_index(w_cnt_nxt[2], w_cnt_nxt[1], w_cnt_nxt[0], v_shift);
                            est_rd_addr <= w_cnt_nxt[1:0];
                            port_idx    <= w_cnt_nxt[2];
                            last        <= w_last_nxt;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nrs_index_seq_gen.sv
// Self-checking bench for nrs_index_seq_gen: random handshake stimulus checked
// against a slot-level model of the NRS index rules.
module tb_nrs_index_seq_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] N_cell_ID = '0;
    logic       num_ports = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [3:0] index_demap;
    logic [2:0] v_shift;
    logic [1:0] est_rd_addr;
    logic       port_idx;
    logic       last;
    logic       busy;
`ifdef NRS_CELL_ID_CHECK_EN
    logic       id_err;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        int idx;
        int addr;
        int port;
        bit lst;
    } ent_t;

    nrs_index_seq_gen #(.ID_W(9), .MAX_PORTS(2), .IDX_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .N_cell_ID  (N_cell_ID),
        .num_ports  (num_ports),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .index_demap(index_demap),
        .v_shift    (v_shift),
        .est_rd_addr(est_rd_addr),
        .port_idx   (port_idx),
        .last       (last),
        .busy       (busy)
`ifdef NRS_CELL_ID_CHECK_EN
        ,
        .id_err     (id_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One full request: mode 0 = always ready, 1 = ready toggles, 2 = random ready.
    // disturb pulses start with a different ID during CALC and during STREAM.
    task automatic run_stream(input int id, input int np, input int mode, input bit disturb);
        ent_t q[$];
        ent_t e;
        ent_t prev;
        int   exp_vs, cyc, got;
        bit   rdy, tog, stalled;
        exp_vs = id % 6;
        for (int p = 0; p <= np; p++)
            for (int s = 0; s < 2; s++)
                for (int m = 0; m < 2; m++) begin
                    e.idx  = (6 * m + ((p == s) ? 0 : 3) + exp_vs) % 12;
                    e.addr = 2 * s + m;
                    e.port = p;
                    e.lst  = (p == np) && (s == 1) && (m == 1);
                    q.push_back(e);
                end
        @(negedge clk);
        N_cell_ID = 9'(id);
        num_ports = (np != 0);
        start     = 1'b1;
        out_ready = (mode == 0);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start id=%0d got=%b want=1", id, busy);
        end
        while (!out_valid && cyc < 20) begin
            if (disturb && cyc == 3) begin
                start     = 1'b1;
                N_cell_ID = 9'd7;
                num_ports = (np == 0);
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL first_valid_latency id=%0d got=%0d want=8", id, cyc);
        end
        checks++;
        if (int'(v_shift) !== exp_vs) begin
            errors++;
            $display("FAIL v_shift id=%0d got=%0d want=%0d", id, v_shift, exp_vs);
        end
        got = 0;
        tog = 1'b0;
        stalled = 1'b0;
        prev = q[0];
        while (got < q.size() && cyc < 400) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       begin tog = ~tog; rdy = tog; end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            start = disturb && (cyc == 9);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL valid_held id=%0d entry=%0d got=%b want=1", id, got, out_valid);
            end else begin
                if (stalled) begin
                    checks++;
                    if (int'(index_demap) !== prev.idx || int'(est_rd_addr) !== prev.addr ||
                        int'(port_idx) !== prev.port || last !== prev.lst) begin
                        errors++;
                        $display("FAIL stall_stable id=%0d entry=%0d got=%0d/%0d/%0d/%b want=%0d/%0d/%0d/%b",
                                 id, got, index_demap, est_rd_addr, port_idx, last,
                                 prev.idx, prev.addr, prev.port, prev.lst);
                    end
                end
                e = q[got];
                checks++;
                if (int'(index_demap) !== e.idx || int'(est_rd_addr) !== e.addr ||
                    int'(port_idx) !== e.port || last !== e.lst) begin
                    errors++;
                    $display("FAIL entry id=%0d np=%0d n=%0d got idx=%0d addr=%0d port=%0d last=%b want idx=%0d addr=%0d port=%0d last=%b",
                             id, np, got, index_demap, est_rd_addr, port_idx, last,
                             e.idx, e.addr, e.port, e.lst);
                end
                prev = e;
                if (rdy) begin
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (got != q.size()) begin
            errors++;
            $display("FAIL stream_timeout id=%0d got=%0d want=%0d entries", id, got, q.size());
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL end_idle id=%0d got valid=%b busy=%b want 0/0", id, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, index_demap, v_shift, est_rd_addr, port_idx, last, busy} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=0",
                     {out_valid, index_demap, v_shift, est_rd_addr, port_idx, last, busy});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_stream(0, 0, 0, 1'b0);
        run_stream(5, 1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_stream(503, 0, 1, 1'b0);
        run_stream(250, 1, 2, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_stream(10, 0, 0, 1'b1);
        run_stream(11, 1, 2, 1'b1);
    endtask

    task automatic test_reset_mid_stream();
        int cyc, acc;
        @(negedge clk);
        N_cell_ID = 9'd20;
        num_ports = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        acc = 0;
        while (acc < 2 && cyc < 30) begin
            if (out_valid) acc++;
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, index_demap, v_shift, est_rd_addr, port_idx, last, busy} !== 13'd0 || acc != 2) begin
            errors++;
            $display("FAIL reset_mid_stream accepted=%0d outputs=%b want 2 and 0",
                     acc, {out_valid, index_demap, v_shift, est_rd_addr, port_idx, last, busy});
        end
        rst_n = 1'b1;
        run_stream(1, 0, 0, 1'b0);
    endtask

    task automatic test_id_range();
`ifdef NRS_CELL_ID_CHECK_EN
        logic [2:0] vs_before;
        run_stream(9, 0, 0, 1'b0);
        vs_before = v_shift;
        @(negedge clk);
        N_cell_ID = 9'd504;
        num_ports = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (id_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL id_err_pulse got err=%b busy=%b want 1/0", id_err, busy);
        end
        @(negedge clk);
        checks++;
        if (id_err !== 1'b0 || busy !== 1'b0 || v_shift !== vs_before) begin
            errors++;
            $display("FAIL id_err_after got err=%b busy=%b vs=%0d want 0/0/%0d",
                     id_err, busy, v_shift, vs_before);
        end
`else
        run_stream(511, 0, 0, 1'b0);
        run_stream(504, 1, 2, 1'b0);
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_stream(int'($urandom_range(0, 503)), int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_sweep();
        for (int id = 0; id <= 503; id++)
            for (int np = 0; np < 2; np++)
                run_stream(id, np, (id + np) % 3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_stream();
        test_id_range();
        test_random();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nrs_index_seq_gen.md
Name: nrs_index_seq_gen

Overview:
- Sequential, parametrised successor to the combinational NRS index generator for the NB-IoT receiver.
- On a start pulse it latches N_cell_ID and the antenna-port count, then computes v_shift = N_cell_ID mod 6 with a fixed-latency restoring reduction.
- It then streams every NRS subcarrier demap index for one slot (all ports, both NRS symbols, both m) to the channel estimator over a valid/ready handshake.

Parameters:
- ID_W, 9, width of the cell ID input.
- MAX_PORTS, 2, maximum NRS antenna ports supported; legal values 1..2.
- IDX_W, 4, width of the demap index (indices 0..11).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- N_cell_ID  in  ID_W  cell ID; sampled with start.
- num_ports  in  1  0 = 1 port, 1 = 2 ports; sampled with start; forced to 0 when MAX_PORTS=1.
- out_ready  in  1  consumer ready.
- out_valid  out  1  index/tags valid.
- index_demap  out  IDX_W  demap subcarrier index.
- v_shift  out  3  latched N_cell_ID mod 6.
- est_rd_addr  out  2  entry within port, j = {sym, m}.
- port_idx  out  1  antenna port of the current entry.
- last  out  1  high with the final entry of the sequence.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE and every output = 0. Takes priority at any point, including mid-CALC or mid-STREAM.
- States: IDLE -> CALC -> STREAM -> IDLE.
- IDLE:
  - start=1 latches N_cell_ID into rem and num_ports, clears k=6, moves to CALC.
  - start=0: no state change.
- CALC: exactly 7 cycles, k = 6 down to 0.
  - Each cycle: if rem >= (6<<k) then rem = rem - (6<<k).
  - After k=0, v_shift = rem[2:0], held until the next start or reset; move to STREAM.
  - Start is accepted at cycle 0; the first out_valid is high at cycle 8.
- STREAM: counters p (port), s (NRS symbol 0/1), m (0/1); est_rd_addr = {s,m}.
  - v: port 0 uses v = 0 for s=0 and 3 for s=1. Port 1 uses v = 3 for s=0 and 0 for s=1.
  - Index: sum = 6*m + v + v_shift (max 14, 4 bits). index_demap = sum - 12 if sum > 11, else sum.
  - Order: p outer, s middle, m inner. Total entries: 4 for 1 port, 8 for 2 ports.
  - Outputs are registered. out_valid stays high and all data/tags stay stable until a cycle with out_ready=1.
  - Counters advance only on out_valid & out_ready, so back-to-back transfers give 1 entry/cycle.
  - last = 1 on the final entry (p = num_ports, s=1, m=1). When it is accepted, out_valid drops the next cycle and the state returns to IDLE.
- start while busy: ignored; latched inputs do not change.
- out_ready may be high before out_valid; no combinational path from out_ready to out_valid.

Optional Feature:
- Macro: NRS_CELL_ID_CHECK_EN.
- Defined:
  - Adds output id_err (1 bit, reset 0).
  - Start with N_cell_ID > 503 pulses id_err for one cycle, stays in IDLE, and leaves v_shift unchanged.
- Undefined:
  - No id_err port.
  - Every ID_W value is accepted and reduced mod 6; e.g. 511 gives v_shift = 1.

Test Plan:
- ID=0, 1 port, out_ready=1 -> v_shift=0; indices 0,6,3,9; est_rd_addr 0..3; last on 4th entry; first valid 8 cycles after start.
- ID=5, 2 ports -> v_shift=5; port 0: 5,11,8,2; port 1: 8,2,5,11; last on 8th entry only.
- ID=503, 1 port, out_ready toggled 1/0 every cycle -> v_shift=5; sequence 5,11,8,2 unchanged; data stable during stalls.
- ID=10 accepted, second start with ID=7 during CALC -> ignored; v_shift=4; indices 4,10,7,1.
- rst_n=0 during STREAM after 2 accepted entries -> next cycle all outputs 0, state IDLE; new start with ID=1 gives 1,7,4,10.
- Sweep ID 0..503 x {1,2} ports against a reference model -> zero mismatches. With NRS_CELL_ID_CHECK_EN, ID=504 gives one id_err pulse and busy stays 0.
